// File: rtl/result_frame_writer.sv
// result_frame_writer: stores a raster stream of processed pixels into an
// IMG_W x IMG_H frame buffer, tracks position, and exposes a registered read port.
module result_frame_writer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              en,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [ADDR_W-1:0] wr_row,
    output logic [ADDR_W-1:0] wr_col
);
    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] mem [N];
    logic [ADDR_W-1:0] wr_addr, row_b, col_b, addr_b, row_nx, col_nx, addr_nx;
    logic wr, col_end, last;

    // frame_start rebases the position to 0 so a same-cycle pixel lands at address 0
    always_comb begin
        row_b    = frame_start ? '0 : wr_row;
        col_b    = frame_start ? '0 : wr_col;
        addr_b   = frame_start ? '0 : wr_addr;
        wr       = en && (frame_start || state == ACTIVE);
        col_end  = col_b == COL_MAX;
        last     = wr && col_end && row_b == ROW_MAX;
        col_nx   = !wr ? col_b : (col_end ? '0 : col_b + 1'b1);
        row_nx   = !wr ? row_b : (last ? '0 : (col_end ? row_b + 1'b1 : row_b));
        addr_nx  = !wr ? addr_b : (last ? '0 : addr_b + 1'b1);
        state_nx = last ? DONE : (frame_start ? ACTIVE : state);
    end

    assign busy = state == ACTIVE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_row     <= row_nx;
            wr_col     <= col_nx;
            wr_addr    <= addr_nx;
            frame_done <= last;
            overflow   <= frame_start ? 1'b0 : (overflow | (en && state != ACTIVE));
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr) mem[addr_b] <= pix_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= (32'(rd_addr) < N) ? mem[rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_result_frame_writer.sv
// tb_result_frame_writer: directed plus random stimulus against a pixel-count
// based reference model of the result frame writer (5x3 frame).
module tb_result_frame_writer;
    localparam int W = 5, H = 3, N = W * H;

    logic       clk = 0, rst_n = 0, frame_start = 0, en = 0, rd_en = 0;
    logic [7:0] pix_in = 0, rd_data;
    logic [15:0] rd_addr = 0, wr_row, wr_col;
    logic       rd_valid, busy, frame_done, overflow;

    int errors = 0, checks = 0;

    // reference: frame position as a pixel count, phase 0=idle 1=active 2=done
    int   m_phase = 0, m_pos = 0;
    bit   m_done = 0, m_ovf = 0, m_rdv = 0;
    logic [7:0] m_rdd = 0;
    logic [7:0] m_mem [N];

    result_frame_writer #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .en(en), .pix_in(pix_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .frame_done(frame_done), .overflow(overflow),
        .wr_row(wr_row), .wr_col(wr_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0; m_pos = 0; m_done = 0; m_ovf = 0; m_rdv = 0; m_rdd = 0;
            return;
        end
        m_rdv = rd_en;
        if (rd_en) m_rdd = (rd_addr < N) ? m_mem[rd_addr] : 8'h00;
        m_done = 0;
        if (frame_start) begin
            m_pos = 0; m_ovf = 0; m_phase = 1;
        end else if (en && m_phase != 1) m_ovf = 1;
        if (en && m_phase == 1) begin
            m_mem[m_pos] = pix_in;
            m_pos++;
            if (m_pos == N) begin
                m_pos = 0; m_phase = 2; m_done = 1;
            end
        end
    endtask

    task automatic step(input bit rs, input bit fs, input bit e, input logic [7:0] px,
                        input bit re, input logic [15:0] ra);
        @(negedge clk);
        rst_n = ~rs; frame_start = fs; en = e; pix_in = px; rd_en = re; rd_addr = ra;
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("wr_row", 32'(wr_row), m_pos / W);
        chk("wr_col", 32'(wr_col), m_pos % W);
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
        chk("rd_data", 32'(rd_data), 32'(m_rdd));
    endtask

    task automatic idle(); step(0, 0, 0, 8'h00, 0, 16'd0); endtask
    task automatic pix(input logic [7:0] px); step(0, 0, 1, px, 0, 16'd0); endtask
    task automatic rd(input logic [15:0] a); step(0, 0, 0, 8'h00, 1, a); endtask

    initial begin
        // reset, then a full contiguous frame
        step(1, 0, 0, 8'h00, 0, 16'd0);
        step(1, 0, 0, 8'h00, 0, 16'd0);
        step(0, 1, 0, 8'h00, 0, 16'd0);
        for (int i = 0; i < N; i++) pix(8'(8'h10 + i));
        idle();
        for (int i = 0; i < N; i++) rd(16'(i));
        // gapped frame with identical contents
        step(0, 1, 0, 8'h00, 0, 16'd0);
        for (int i = 0; i < N; i++) begin
            pix(8'(8'h10 + i));
            idle();
            idle();
        end
        for (int i = 0; i < N; i++) rd(16'(i));
        // en while DONE sets overflow and leaves the buffer alone
        pix(8'hEE);
        rd(16'd0);
        step(0, 1, 0, 8'h00, 0, 16'd0);
        // restart mid-frame with a same-cycle pixel
        for (int i = 0; i < 7; i++) pix(8'(8'h20 + i));
        step(0, 1, 1, 8'hAA, 0, 16'd0);
        rd(16'd0);
        // read-before-write on addr 3, then out-of-range read
        pix(8'h31);
        pix(8'h32);
        step(0, 0, 1, 8'h55, 1, 16'd3);
        rd(16'd3);
        rd(16'd20);
        rd(16'd0);
        // reset mid-frame, then stray en in IDLE
        step(0, 1, 0, 8'h00, 0, 16'd0);
        for (int i = 0; i < 8; i++) pix(8'(8'h40 + i));
        step(1, 0, 0, 8'h00, 0, 16'd0);
        idle();
        pix(8'h99);
        idle();
        // random traffic
        step(0, 1, 0, 8'h00, 0, 16'd0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(99) == 0, $urandom_range(39) == 0, $urandom_range(2) != 0,
                 8'($urandom), $urandom_range(1) == 1, 16'($urandom_range(N + 4)));
        step(0, 0, 0, 8'h00, 0, 16'd0);
        for (int i = 0; i < N; i++) rd(16'(i));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
